// File: rtl/if_id_reg_if.sv
// IF/ID pipeline register bus: fetch-side inputs, hazard-unit inputs,
// and the registered ID-side outputs plus hazard controls.
interface if_id_reg_if;
    logic [31:0] instIn;
    logic [31:0] pcIn;
    logic [1:0]  pcSrc;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic        clrCnt;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        validOut;
    logic        pcWrite;
    logic        ctrlBubble;
    logic [7:0]  stallCnt;
    logic [7:0]  flushCnt;

    // Driver side (fetch / control / bench)
    modport master (
        output instIn, pcIn, pcSrc, idExMemRead, idExRt, clrCnt,
        input  instOut, pcOut, validOut, pcWrite, ctrlBubble, stallCnt, flushCnt
    );

    // Register side (the if_id_reg block)
    modport slave (
        input  instIn, pcIn, pcSrc, idExMemRead, idExRt, clrCnt,
        output instOut, pcOut, validOut, pcWrite, ctrlBubble, stallCnt, flushCnt
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load-use hazard detection, control-hazard
// flush, and saturating stall/flush event counters.
module if_id_reg (
    input logic        clk,
    input logic        rst,      // asynchronous, active-low
    if_id_reg_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic       uses_rs;
    logic       uses_rt;
    logic       load_use;
    logic       flush;

    // Hazard detection on the instruction currently held in ID
    always_comb begin
        opcode   = inst_q[31:26];
        rs_f     = inst_q[25:21];
        rt_f     = inst_q[20:16];
        uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE)   || (opcode == OP_SW);
        uses_rs  = (opcode != OP_J);
        load_use = valid_q && bus.idExMemRead && (bus.idExRt != 5'd0) &&
                   ((uses_rs && (bus.idExRt == rs_f)) ||
                    (uses_rt && (bus.idExRt == rt_f)));
        // A stalled or bubble slot cannot redirect, so pcSrc is ignored then
        flush    = valid_q && (bus.pcSrc != 2'b00) && !load_use;
    end

    // Next-state selection: stall holds, flush inserts a bubble, else load
    always_comb begin
        inst_d  = bus.instIn;
        pc_d    = bus.pcIn;
        valid_d = 1'b1;
        if (load_use) begin
            inst_d  = inst_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else if (flush) begin
            inst_d  = 32'h0000_0000;
            pc_d    = 32'h0000_0000;
            valid_d = 1'b0;
        end
    end

    // Saturating event counters; clear wins over any increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.clrCnt) begin
            stall_cnt_d = 8'd0;
            flush_cnt_d = 8'd0;
        end else begin
            if (load_use && (stall_cnt_q != 8'hFF)) begin
                stall_cnt_d = stall_cnt_q + 8'd1;
            end
            if (flush && (flush_cnt_q != 8'hFF)) begin
                flush_cnt_d = flush_cnt_q + 8'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q      <= 32'h0000_0000;
            pc_q        <= 32'h0000_0000;
            valid_q     <= 1'b0;
            stall_cnt_q <= 8'd0;
            flush_cnt_q <= 8'd0;
        end else begin
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.instOut    = inst_q;
    assign bus.pcOut      = pc_q;
    assign bus.validOut   = valid_q;
    assign bus.pcWrite    = !load_use;
    assign bus.ctrlBubble = load_use;
    assign bus.stallCnt   = stall_cnt_q;
    assign bus.flushCnt   = flush_cnt_q;

endmodule
